// File: rtl/register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH MIPS register file: two combinational read ports,
// one write port committed on the rising edge, $0 hardwired to zero, optional write bypass.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 2;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] raddr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (reg_write && (write_reg != '0)) begin
            regs[write_reg] <= write_data;
        end
    end

    assign raddr = {read_reg2, read_reg1};

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
            always_comb begin
                rdata[p] = regs[raddr[p]];
                if (reset)
                    rdata[p] = '0;
                else if (raddr[p] == '0)
                    rdata[p] = '0;
                else if ((BYPASS != 0) && reg_write && (write_reg == raddr[p]))
                    rdata[p] = write_data;
            end
        end
    endgenerate

    assign read_data1 = rdata[0];
    assign read_data2 = rdata[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file share stimulus;
// every expected value is a hand-computed constant or i*0x0101_0101.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1; write_reg = a; write_data = d;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_reg1 = a1; read_reg2 = a2;
        #2;
    endtask

    initial begin
        logic [31:0] e1, e2;
        reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0;
        #1;

        // Reset: outputs zero during reset, and all indices zero afterwards
        rd(5'd1, 5'd31);
        chk("rst_during_p1", rd1_b, 32'h0);
        chk("rst_during_p2", rd2_n, 32'h0);
        tick(); tick();
        reset = 1'b0;
        rd(5'd0, 5'd1);
        chk("empty_r0", rd1_b, 32'h0);
        chk("empty_r1", rd2_b, 32'h0);
        rd(5'd31, 5'd31);
        chk("empty_r31_p1", rd1_n, 32'h0);
        chk("empty_r31_p2", rd2_b, 32'h0);

        // Basic write/read
        wr(5'd8, 32'h0000_1010);
        wr(5'd9, 32'h0000_1000);
        rd(5'd8, 5'd9);
        chk("basic_p1", rd1_b, 32'h0000_1010);
        chk("basic_p2", rd2_b, 32'h0000_1000);
        chk("basic_nob_p1", rd1_n, 32'h0000_1010);
        chk("basic_alu_add", rd1_b + rd2_b, 32'h0000_2010);

        // $0 protection, no bypass onto $0
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
        rd(5'd0, 5'd0);
        chk("r0_wcyc_p1", rd1_b, 32'h0);
        chk("r0_wcyc_p2", rd2_b, 32'h0);
        tick();
        reg_write = 1'b0;
        rd(5'd0, 5'd0);
        chk("r0_after_p1", rd1_b, 32'h0);
        chk("r0_after_nob", rd2_n, 32'h0);

        // Bypass vs. no bypass, both ports aliasing write_reg
        wr(5'd5, 32'h1);
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        rd(5'd5, 5'd5);
        chk("byp_same_p1", rd1_b, 32'hDEAD_BEEF);
        chk("byp_same_p2", rd2_b, 32'hDEAD_BEEF);
        chk("nob_same_p1", rd1_n, 32'h1);
        chk("nob_same_p2", rd2_n, 32'h1);
        tick();
        reg_write = 1'b0;
        #1;
        chk("byp_next_p1", rd1_b, 32'hDEAD_BEEF);
        chk("nob_next_p1", rd1_n, 32'hDEAD_BEEF);
        chk("nob_next_p2", rd2_n, 32'hDEAD_BEEF);

        // Reset beats write; reset mid-program discards contents
        wr(5'd3, 32'h1234);
        rd(5'd3, 5'd8);
        chk("pre_rst_r3", rd1_n, 32'h1234);
        reset = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hAAAA_5555;
        #1;
        chk("rst_wr_during_b", rd1_b, 32'h0);
        tick();
        reset = 1'b0; reg_write = 1'b0;
        rd(5'd3, 5'd8);
        chk("rst_wr_r3_b", rd1_b, 32'h0);
        chk("rst_wr_r3_n", rd1_n, 32'h0);
        chk("rst_clr_r8", rd2_b, 32'h0);
        // reg_write low: toggling write_data changes nothing
        write_data = 32'h5555_AAAA;
        #1;
        chk("nowe_comb_r3", rd1_b, 32'h0);
        tick();
        write_data = 32'h0F0F_0F0F;
        tick();
        chk("nowe_r3_b", rd1_b, 32'h0);
        chk("nowe_r3_n", rd1_n, 32'h0);

        // Sweep: i <- i*0x01010101, read pairs (i, 31-i)
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(31 - i) * 32'h0101_0101;
            chk($sformatf("sweep_p1_%0d", i), rd1_b, e1);
            chk($sformatf("sweep_p2_%0d", 31 - i), rd2_n, e2);
        end

        // Back-to-back writes to the same index: last wins
        wr(5'd7, 32'h11);
        wr(5'd7, 32'h22);
        rd(5'd7, 5'd7);
        chk("b2b_r7_b", rd1_b, 32'h22);
        chk("b2b_r7_n", rd2_n, 32'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
